// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration command initiator.
// Holds state encoding, register addresses and response byte codes.
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RESP
  } state_e;

  localparam logic [3:0] ADDR_DEFAULTS    = 4'h0;
  localparam logic [3:0] ADDR_PARITY      = 4'h9;
  localparam logic [3:0] ADDR_PARITY_TYPE = 4'hA;
  localparam logic [3:0] ADDR_STOP_BITS   = 4'hB;
  localparam logic [3:0] ADDR_FRAME_LEN   = 4'hC;

  localparam logic [3:0] READ_CODE = 4'hF;

  localparam logic [7:0] RSP_WR_OK    = 8'h00;
  localparam logic [3:0] RSP_RD       = 4'h1;
  localparam logic [7:0] RSP_DEFAULTS = 8'hD0;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hE0;
  localparam logic [7:0] RSP_NO_DATA  = 8'hE1;
  localparam logic [7:0] RSP_BAD_ADDR = 8'hE2;

  function automatic logic addr_known(input logic [3:0] addr);
    return (addr == ADDR_DEFAULTS)  || (addr == ADDR_PARITY)    ||
           (addr == ADDR_PARITY_TYPE) || (addr == ADDR_STOP_BITS) ||
           (addr == ADDR_FRAME_LEN);
  endfunction

endpackage

// File: rtl/cfg_ack_timer.sv
// Saturating wait counter for the register-file acknowledge.
// expired flags the last permitted wait cycle, so the master leaves after ACK_TIMEOUT cycles.
module cfg_ack_timer #(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk_16bd,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(ACK_TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The increment at the end of this cycle would reach ACK_TIMEOUT.
  assign expired = (count_q >= LAST);

endmodule

// File: rtl/uart_cfg_master.sv
// Turns UART command bytes into single-cycle config register accesses
// and returns one status byte per command; every output is registered.
module uart_cfg_master
  import uart_cfg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk_16bd,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       cfg_valid,
  output logic [3:0] cfg_address,
  output logic [3:0] cfg_data,
  input  logic       cfg_ack,
  input  logic [3:0] cfg_data_out,
  input  logic       cfg_data_out_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       rx_ready_q, rx_ready_d;
  logic       cfg_valid_q, cfg_valid_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       busy_q, busy_d;
  logic       timer_clear, timer_en, timer_expired;

  cfg_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk_16bd(clk_16bd),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_data_d   = tx_data_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_ready_q) begin
          addr_d = rx_data[7:4];
          data_d = rx_data[3:0];
          if (addr_known(rx_data[7:4])) begin
            state_d = ST_ISSUE;
          end else begin
            state_d   = ST_RESP;
            tx_data_d = RSP_BAD_ADDR;
          end
        end
      end
      ST_ISSUE: begin
        timer_clear = 1'b1;
        // Restore-defaults is fire-and-forget: the register file never acks it.
        if (addr_q == ADDR_DEFAULTS) begin
          state_d   = ST_RESP;
          tx_data_d = RSP_DEFAULTS;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_en = !cfg_ack;
        if (cfg_ack) begin
          state_d = ST_RESP;
          if (data_q != READ_CODE) begin
            tx_data_d = RSP_WR_OK;
          end else if (cfg_data_out_valid) begin
            tx_data_d = {RSP_RD, cfg_data_out};
          end else begin
            tx_data_d = RSP_NO_DATA;
          end
        end else if (timer_expired) begin
          state_d   = ST_RESP;
          tx_data_d = RSP_TIMEOUT;
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    rx_ready_d  = (state_d == ST_IDLE);
    cfg_valid_d = (state_d == ST_ISSUE);
    tx_valid_d  = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_ready_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      cfg_valid_q <= cfg_valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign cfg_valid   = cfg_valid_q;
  assign cfg_address = addr_q;
  assign cfg_data    = data_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cfg_master.sv
// Directed bench for uart_cfg_master with a small register-file responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_cfg_master;

  localparam int ACK_TIMEOUT = 8;

  logic       clk_16bd = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       cfg_valid;
  logic [3:0] cfg_address;
  logic [3:0] cfg_data;
  logic       cfg_ack;
  logic [3:0] cfg_data_out;
  logic       cfg_data_out_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;

  int checks = 0;
  int passes = 0;

  // Register-file responder: acks one cycle after seeing cfg_valid.
  logic       model_en = 1'b1;
  logic       force_ack = 1'b0;
  logic       model_ack = 1'b0;
  logic       model_dv = 1'b0;
  logic [3:0] model_do = 4'h0;
  logic       pend = 1'b0;
  logic       pend_read = 1'b0;
  logic [3:0] pend_addr = 4'h0;
  logic [3:0] pend_data = 4'h0;
  logic [3:0] regs [16];

  assign cfg_ack            = model_ack | force_ack;
  assign cfg_data_out       = model_do;
  assign cfg_data_out_valid = model_dv;

  always #5 clk_16bd = ~clk_16bd;

  uart_cfg_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_16bd          (clk_16bd),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .cfg_valid         (cfg_valid),
    .cfg_address       (cfg_address),
    .cfg_data          (cfg_data),
    .cfg_ack           (cfg_ack),
    .cfg_data_out      (cfg_data_out),
    .cfg_data_out_valid(cfg_data_out_valid),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy)
  );

  always @(negedge clk_16bd) begin
    model_ack = pend;
    model_dv  = pend && pend_read;
    model_do  = (pend && pend_read) ? regs[pend_addr] : 4'h0;
    if (pend && !pend_read) regs[pend_addr] = pend_data;
    pend      = model_en && cfg_valid && (cfg_address != 4'h0);
    pend_addr = cfg_address;
    pend_data = cfg_data;
    pend_read = (cfg_data == 4'hF);
  end

  // Present a byte and hold it until accepted; returns in the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk_16bd);
      n++;
    end
    checks++;
    if (n >= 20) $display("FAIL send_accept byte=%h rx_ready=%b exp=1", b, rx_ready);
    else passes++;
    @(negedge clk_16bd);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_16bd);
    checks++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); else passes++;
    checks++; if (cfg_valid !== 1'b0) $display("FAIL rst_cfg_valid got=%b exp=0", cfg_valid); else passes++;
    checks++; if (cfg_address !== 4'h0 || cfg_data !== 4'h0) $display("FAIL rst_cfg_bus got=%h/%h exp=0/0", cfg_address, cfg_data); else passes++;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL rst_tx got=%b/%h exp=0/00", tx_valid, tx_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passes++;
    rst = 1'b0;
    @(negedge clk_16bd);
    checks++; if (rx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_rst_idle got=%b/%b exp=1/0", rx_ready, busy); else passes++;
    $display("reset released: rx_ready=%b busy=%b", rx_ready, busy);
  endtask

  task automatic test_read();
    logic [7:0] cmds [2];
    logic [7:0] exps [2];
    cmds[0] = 8'h9F; exps[0] = 8'h11;
    cmds[1] = 8'hCF; exps[1] = 8'h18;
    for (int i = 0; i < 2; i++) begin
      send_byte(cmds[i]);
      checks++; if (cfg_valid !== 1'b1 || cfg_address !== cmds[i][7:4] || cfg_data !== 4'hF) $display("FAIL rd_issue got=%b/%h/%h exp=1/%h/f", cfg_valid, cfg_address, cfg_data, cmds[i][7:4]); else passes++;
      repeat (2) @(negedge clk_16bd);
      checks++; if (tx_valid !== 1'b1 || tx_data !== exps[i]) $display("FAIL rd_resp got=%b/%h exp=1/%h", tx_valid, tx_data, exps[i]); else passes++;
      $display("rx %h -> tx %h", cmds[i], tx_data);
      @(negedge clk_16bd);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hC7);
    checks++; if (cfg_valid !== 1'b1 || cfg_address !== 4'hC || cfg_data !== 4'h7) $display("FAIL wr_issue got=%b/%h/%h exp=1/c/7", cfg_valid, cfg_address, cfg_data); else passes++;
    rx_data  = 8'hCF;
    rx_valid = 1'b1;
    @(negedge clk_16bd);
    checks++; if (cfg_valid !== 1'b0 || rx_ready !== 1'b0) $display("FAIL wr_single_strobe got=%b/%b exp=0/0", cfg_valid, rx_ready); else passes++;
    @(negedge clk_16bd);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00 || rx_ready !== 1'b0) $display("FAIL wr_resp got=%b/%h/%b exp=1/00/0", tx_valid, tx_data, rx_ready); else passes++;
    $display("rx c7 -> tx %h", tx_data);
    @(negedge clk_16bd);
    checks++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) $display("FAIL b2b_ready got=%b/%b exp=1/0", rx_ready, tx_valid); else passes++;
    @(negedge clk_16bd);
    rx_valid = 1'b0;
    checks++; if (cfg_valid !== 1'b1 || cfg_address !== 4'hC || cfg_data !== 4'hF) $display("FAIL b2b_issue got=%b/%h/%h exp=1/c/f", cfg_valid, cfg_address, cfg_data); else passes++;
    repeat (2) @(negedge clk_16bd);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h17) $display("FAIL b2b_readback got=%b/%h exp=1/17", tx_valid, tx_data); else passes++;
    $display("rx cf -> tx %h", tx_data);
    @(negedge clk_16bd);
  endtask

  task automatic test_defaults_bad_addr();
    send_byte(8'h00);
    checks++; if (cfg_valid !== 1'b1 || cfg_address !== 4'h0) $display("FAIL def_issue got=%b/%h exp=1/0", cfg_valid, cfg_address); else passes++;
    @(negedge clk_16bd);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hD0 || cfg_valid !== 1'b0) $display("FAIL def_resp got=%b/%h/%b exp=1/d0/0", tx_valid, tx_data, cfg_valid); else passes++;
    $display("rx 00 -> tx %h", tx_data);
    @(negedge clk_16bd);
    checks++; if (rx_ready !== 1'b1) $display("FAIL def_idle got=%b exp=1", rx_ready); else passes++;
    send_byte(8'h5F);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hE2 || cfg_valid !== 1'b0) $display("FAIL bad_resp got=%b/%h/%b exp=1/e2/0", tx_valid, tx_data, cfg_valid); else passes++;
    $display("rx 5f -> tx %h", tx_data);
    @(negedge clk_16bd);
    checks++; if (cfg_valid !== 1'b0 || rx_ready !== 1'b1) $display("FAIL bad_idle got=%b/%b exp=0/1", cfg_valid, rx_ready); else passes++;
  endtask

  task automatic test_timeout();
    int n = 0;
    model_en = 1'b0;
    send_byte(8'hA1);
    while (tx_valid !== 1'b1 && n < 40) begin
      @(negedge clk_16bd);
      n++;
    end
    checks++; if (n != ACK_TIMEOUT + 1) $display("FAIL to_latency got=%0d exp=%0d", n, ACK_TIMEOUT + 1); else passes++;
    checks++; if (tx_data !== 8'hE0) $display("FAIL to_resp got=%h exp=e0", tx_data); else passes++;
    $display("rx a1 (no ack) -> tx %h after %0d cycles", tx_data, n);
    @(negedge clk_16bd);
    send_byte(8'hA1);
    repeat (ACK_TIMEOUT) @(negedge clk_16bd);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) $display("FAIL to_not_early got=%b/%b exp=0/1", tx_valid, busy); else passes++;
    force_ack = 1'b1;
    @(negedge clk_16bd);
    force_ack = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) $display("FAIL to_ack_wins got=%b/%h exp=1/00", tx_valid, tx_data); else passes++;
    $display("rx a1 (ack on expiry) -> tx %h", tx_data);
    @(negedge clk_16bd);
    model_en = 1'b1;
  endtask

  task automatic test_back_pressure();
    tx_ready = 1'b0;
    send_byte(8'h9F);
    repeat (2) @(negedge clk_16bd);
    rx_data  = 8'hC3;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h11 || rx_ready !== 1'b0) $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/11/0", i, tx_valid, tx_data, rx_ready); else passes++;
      @(negedge clk_16bd);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk_16bd);
    checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) $display("FAIL bp_release got=%b/%b exp=0/1", tx_valid, rx_ready); else passes++;
    @(negedge clk_16bd);
    checks++; if (cfg_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_dropped_byte got=%b/%b exp=0/0", cfg_valid, busy); else passes++;
    $display("rx 9f (held 10 cycles) -> tx 11 released");
  endtask

  task automatic test_reset_mid();
    logic saw_tx = 1'b0;
    model_en = 1'b0;
    send_byte(8'hB0);
    repeat (2) @(negedge clk_16bd);
    rst = 1'b1;
    @(negedge clk_16bd);
    rst = 1'b0;
    checks++; if (rx_ready !== 1'b0 || cfg_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_ctrl got=%b/%b/%b exp=0/0/0", rx_ready, cfg_valid, busy); else passes++;
    checks++; if (cfg_address !== 4'h0 || cfg_data !== 4'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL mid_rst_data got=%h/%h/%b/%h exp=0/0/0/00", cfg_address, cfg_data, tx_valid, tx_data); else passes++;
    force_ack = 1'b1;
    @(negedge clk_16bd);
    force_ack = 1'b0;
    checks++; if (rx_ready !== 1'b1) $display("FAIL mid_rst_idle got=%b exp=1", rx_ready); else passes++;
    for (int i = 0; i < 5; i++) begin
      if (tx_valid === 1'b1) saw_tx = 1'b1;
      @(negedge clk_16bd);
    end
    checks++; if (saw_tx !== 1'b0) $display("FAIL late_ack_resp got=%b exp=0", saw_tx); else passes++;
    $display("rx b0 interrupted by reset -> no response");
    model_en = 1'b1;
  endtask

  initial begin
    regs = '{default: 4'h0};
    regs[9]  = 4'h1;
    regs[12] = 4'h8;
    test_reset();
    test_read();
    test_back_to_back();
    test_defaults_bad_addr();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
